// File: rtl/commit_tracker_if.sv
// Commit bus between the writeback stage, the retirement tracker and difftest.
// The master side (pipeline) drives the c_* retire lanes and a0_value.
// The slave side (tracker) drives the registered d_* lanes.
interface commit_tracker_if #(
    parameter int NCOMMIT = 2,
    parameter int XLEN    = 64
);
    // Retire lanes from writeback, channel 0 oldest
    logic [NCOMMIT-1:0]      c_valid;
    logic [NCOMMIT*XLEN-1:0] c_pc;
    logic [NCOMMIT*32-1:0]   c_instr;
    logic [NCOMMIT-1:0]      c_wen;
    logic [NCOMMIT*5-1:0]    c_wdest;
    logic [NCOMMIT*XLEN-1:0] c_wdata;
    logic [NCOMMIT-1:0]      c_skip;
    logic [XLEN-1:0]         a0_value;

    // Registered commit lanes toward difftest
    logic [NCOMMIT-1:0]      d_valid;
    logic [NCOMMIT*XLEN-1:0] d_pc;
    logic [NCOMMIT*32-1:0]   d_instr;
    logic [NCOMMIT-1:0]      d_wen;
    logic [NCOMMIT*5-1:0]    d_wdest;
    logic [NCOMMIT*XLEN-1:0] d_wdata;
    logic [NCOMMIT-1:0]      d_skip;

    modport master (
        output c_valid, c_pc, c_instr, c_wen, c_wdest, c_wdata, c_skip, a0_value,
        input  d_valid, d_pc, d_instr, d_wen, d_wdest, d_wdata, d_skip
    );

    modport slave (
        input  c_valid, c_pc, c_instr, c_wen, c_wdest, c_wdata, c_skip, a0_value,
        output d_valid, d_pc, d_instr, d_wen, d_wdest, d_wdata, d_skip
    );
endinterface

// File: rtl/commit_tracker.sv
// Retirement tracker: registers up to NCOMMIT retirements per cycle for
// difftest, keeps cycle / retired-instruction counters, detects the halt
// instruction and reports a one-cycle trap event, then stops retiring.
module commit_tracker #(
    parameter int          NCOMMIT    = 2,
    parameter int          XLEN       = 64,
    parameter logic [31:0] TRAP_INSTR = 32'h0000_006b,
    parameter int          CODE_REG_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    commit_tracker_if.slave       bus,
    output logic [63:0]           cycle_cnt,
    output logic [63:0]           instr_cnt,
    output logic                  trap_valid,
    output logic [CODE_REG_W-1:0] trap_code,
    output logic [XLEN-1:0]       trap_pc,
    output logic                  halted
);

    localparam int CNT_W = $clog2(NCOMMIT + 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        TRAP   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state, state_next;

    // Masked (retiring) view of the current cycle's lanes
    logic [NCOMMIT-1:0]      keep;
    logic                    trap_hit;
    logic [XLEN-1:0]         hit_pc;
    logic [CNT_W-1:0]        retire_cnt;
    logic [NCOMMIT*XLEN-1:0] m_pc;
    logic [NCOMMIT*32-1:0]   m_instr;
    logic [NCOMMIT-1:0]      m_wen;
    logic [NCOMMIT*5-1:0]    m_wdest;
    logic [NCOMMIT*XLEN-1:0] m_wdata;
    logic [NCOMMIT-1:0]      m_skip;

    // Registered commit lanes
    logic [NCOMMIT-1:0]      d_valid_q;
    logic [NCOMMIT*XLEN-1:0] d_pc_q;
    logic [NCOMMIT*32-1:0]   d_instr_q;
    logic [NCOMMIT-1:0]      d_wen_q;
    logic [NCOMMIT*5-1:0]    d_wdest_q;
    logic [NCOMMIT*XLEN-1:0] d_wdata_q;
    logic [NCOMMIT-1:0]      d_skip_q;

    logic [CODE_REG_W-1:0]   trap_code_q;
    logic [XLEN-1:0]         trap_pc_q;

    // Walk lanes oldest-first; the first trap lane retires, younger lanes are dropped
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        keep       = '0;
        trap_hit   = 1'b0;
        hit_pc     = '0;
        retire_cnt = '0;
        m_pc       = '0;
        m_instr    = '0;
        m_wen      = '0;
        m_wdest    = '0;
        m_wdata    = '0;
        m_skip     = '0;
        if (state == RUN) begin
            for (int i = 0; i < NCOMMIT; i++) begin
                if (bus.c_valid[i] && !trap_hit) begin
                    keep[i]                 = 1'b1;
                    retire_cnt              = retire_cnt + CNT_W'(1);
                    m_pc[i*XLEN +: XLEN]    = bus.c_pc[i*XLEN +: XLEN];
                    m_instr[i*32 +: 32]     = bus.c_instr[i*32 +: 32];
                    m_wen[i]                = bus.c_wen[i] && (bus.c_wdest[i*5 +: 5] != 5'd0);
                    m_wdest[i*5 +: 5]       = bus.c_wdest[i*5 +: 5];
                    m_wdata[i*XLEN +: XLEN] = bus.c_wdata[i*XLEN +: XLEN];
                    m_skip[i]               = bus.c_skip[i];
                    if (bus.c_instr[i*32 +: 32] == TRAP_INSTR) begin
                        trap_hit = 1'b1;
                        hit_pc   = bus.c_pc[i*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    // Next-state: trap detection moves RUN->TRAP, TRAP lasts one cycle, HALTED is terminal
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (trap_hit) state_next = TRAP;
            TRAP:    state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
        if (!reset) state <= RUN;
        else        state <= state_next;
    end

    // One-cycle commit pipeline toward difftest; unkept lanes are held at zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_valid_q <= '0;
            d_pc_q    <= '0;
            d_instr_q <= '0;
            d_wen_q   <= '0;
            d_wdest_q <= '0;
            d_wdata_q <= '0;
            d_skip_q  <= '0;
        end else begin
            d_valid_q <= keep;
            d_pc_q    <= m_pc;
            d_instr_q <= m_instr;
            d_wen_q   <= m_wen;
            d_wdest_q <= m_wdest;
            d_wdata_q <= m_wdata;
            d_skip_q  <= m_skip;
        end
    end

    // Counters advance only while running; the detect cycle still counts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (state == RUN) begin
            cycle_cnt <= cycle_cnt + 64'd1;
            instr_cnt <= instr_cnt + 64'(retire_cnt);
        end
    end

    // Snapshot trap code and PC in the detect cycle; held until reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trap_code_q <= '0;
            trap_pc_q   <= '0;
        end else if (state == RUN && trap_hit) begin
            trap_code_q <= bus.a0_value[CODE_REG_W-1:0];
            trap_pc_q   <= hit_pc;
        end
    end

    assign bus.d_valid = d_valid_q;
    assign bus.d_pc    = d_pc_q;
    assign bus.d_instr = d_instr_q;
    assign bus.d_wen   = d_wen_q;
    assign bus.d_wdest = d_wdest_q;
    assign bus.d_wdata = d_wdata_q;
    assign bus.d_skip  = d_skip_q;

    assign trap_valid = (state == TRAP);
    assign halted     = (state != RUN);
    assign trap_code  = trap_code_q;
    assign trap_pc    = trap_pc_q;

endmodule
